timer_peri: RTL and testbench
=============================

TIMER_PERI -- requirements
Module: timer_peri

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10, meaning the first of five consecutive peripheral-bus register addresses (BASE_ADDR..BASE_ADDR+4).
REQ-002 SHALL have port clk_ip  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_ip  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port addr_ip  input  8  peripheral bus address from the CPU.
REQ-005 SHALL have port data_ip  input  8  peripheral bus write data from the CPU (W register).
REQ-006 SHALL have port wr_en_ip  input  1  bus write strobe, one cycle per store.
REQ-007 SHALL have port rd_en_ip  input  1  bus read strobe, one cycle per load.
REQ-008 SHALL have port data_op  output  8  bus read data.
REQ-009 SHALL have port capture_ip  input  1  asynchronous external capture event, used only under TIMER_PERI_CAPTURE_EN.
REQ-010 SHALL have port irq_op  output  1  level interrupt request to the CPU irq input.

Function
REQ-011 Register map SHALL be: +0 CTRL (bit0 EN, bit1 IE, bit2 ARL auto-reload, bits5:3 PSC, bits7:6 read 0); +1 CNT; +2 CMP; +3 STAT (bit0 MF match flag, bit1 CF capture flag, others read 0); +4 CAP.
REQ-012 data_op SHALL be combinational: the addressed register value when rd_en_ip=1 and addr_ip is in range, otherwise 8'h00 (zero-latency, OR-able bus).
REQ-013 Writes SHALL take effect on the rising edge where wr_en_ip=1 and addr_ip is in range; writes to CAP and unused bits are ignored.
REQ-014 STAT bits SHALL be write-1-to-clear; writing 0 leaves a bit unchanged.
REQ-015 An 8-bit prescaler SHALL produce tick every cycle when PSC=0, else once every 2^PSC cycles (PSC=7: every 128 cycles); it SHALL be held at 0 while EN=0.
REQ-016 On each tick with EN=1: if CNT==CMP, MF SHALL be set and CNT SHALL load 8'h00 when ARL=1 or increment when ARL=0; otherwise CNT SHALL increment modulo 256 (8'hFF -> 8'h00, no flag).
REQ-017 A write to CNT SHALL override any same-cycle tick update and SHALL reset the prescaler to 0.
REQ-018 A hardware set of MF or CF in the same cycle as a W1C of that bit SHALL leave the bit set (set wins).
REQ-019 irq_op SHALL equal MF AND IE, combinational from registered state, with no glitch from bus activity.
REQ-020 Clearing EN SHALL freeze CNT and the prescaler within the same edge; MF is not affected.
REQ-021 Writing CMP while counting SHALL take effect on the next tick comparison.

Reset
REQ-022 While reset_ip=1, CTRL, CNT, CMP, STAT, CAP, prescaler and capture synchronizer SHALL be 8'h00/0 immediately, independent of clk_ip.
REQ-023 After reset, irq_op=0 and data_op=8'h00 while rd_en_ip=0.
REQ-024 Reset asserted mid-count SHALL abandon the count; first tick after release and EN=1 SHALL be counted from prescaler 0.

Configuration
REQ-025 Macro TIMER_PERI_CAPTURE_EN SHALL compile in the capture unit: capture_ip passes a 2-flop synchronizer; a synchronized rising edge copies CNT (pre-update value of that cycle) into CAP and sets CF; capture is independent of EN.
REQ-026 Without TIMER_PERI_CAPTURE_EN, capture_ip SHALL be ignored, CAP and CF SHALL read 0, and no synchronizer flops exist.

Verification
REQ-027 Reset, write CMP=8'h03, CTRL=8'h07 (EN,IE,ARL,PSC=0) -> CNT reads 0,1,2,3,0 on successive cycles; MF and irq_op rise on the edge of the 3->0 tick.
REQ-028 MF set, write STAT=8'h01 -> irq_op falls next edge; repeat with the write coincident with a match tick -> MF remains 1.
REQ-029 CTRL=8'h19 (EN, PSC=3), CMP=8'hFF, ARL=0 -> CNT increments every 8 cycles; at 8'hFF tick MF sets and CNT wraps to 8'h00.
REQ-030 While counting, write CNT=8'h80 on a tick cycle -> CNT reads 8'h80 next cycle and next increment occurs 2^PSC cycles later.
REQ-031 Assert reset_ip asynchronously between clock edges mid-count -> all registers and irq_op read 0 before the next edge.
REQ-032 With TIMER_PERI_CAPTURE_EN, pulse capture_ip while CNT=8'h42 -> after 2-3 cycles CAP=8'h42 (±sync latency value), CF=1; without the macro CAP=8'h00, CF=0.

Source files
------------

// File: rtl/timer_peri.sv
// timer_peri: 8-bit bus-mapped timer with prescaler, compare match IRQ and optional input capture
// Ports: clk_ip/reset_ip (async active-high), addr_ip/data_ip/wr_en_ip/rd_en_ip/data_op CPU bus,
//        capture_ip external capture event, irq_op level interrupt (MF & IE).
// Register map at BASE_ADDR+: 0 CTRL{PSC[5:3],ARL,IE,EN}, 1 CNT, 2 CMP, 3 STAT{CF,MF} W1C, 4 CAP.
// Define TIMER_PERI_CAPTURE_EN to build the capture unit; otherwise CAP and CF read 0.
module timer_peri #(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic       clk_ip,
    input  logic       reset_ip,
    input  logic [7:0] addr_ip,
    input  logic [7:0] data_ip,
    input  logic       wr_en_ip,
    input  logic       rd_en_ip,
    output logic [7:0] data_op,
    input  logic       capture_ip,
    output logic       irq_op
);
    logic [5:0] ctrl_q, ctrl_d;
    logic [7:0] cnt_q, cnt_d, cmp_q, cmp_d, psc_q, psc_d, cap_q, cap_d;
    logic       mf_q, mf_d, cf_q, cf_d;
    logic [7:0] off, mask;
    logic       in_rng, wr_ctrl, wr_cnt, wr_cmp, wr_stat, en, tick, hit, cap_evt;

    // Unsigned wrap makes addresses below BASE_ADDR land out of range too.
    assign off     = addr_ip - BASE_ADDR;
    assign in_rng  = off <= 8'd4;
    assign wr_ctrl = wr_en_ip && in_rng && off == 8'd0;
    assign wr_cnt  = wr_en_ip && in_rng && off == 8'd1;
    assign wr_cmp  = wr_en_ip && in_rng && off == 8'd2;
    assign wr_stat = wr_en_ip && in_rng && off == 8'd3;
    // A CTRL write clearing EN already freezes the count on its own edge.
    assign en      = ctrl_q[0] && !(wr_ctrl && !data_ip[0]);
    assign mask    = ~(8'hFF << ctrl_q[5:3]);
    assign tick    = en && ((psc_q & mask) == mask);
    assign hit     = tick && cnt_q == cmp_q;
    assign irq_op  = mf_q && ctrl_q[1];

`ifdef TIMER_PERI_CAPTURE_EN
    logic [2:0] sync_q;
    // sync_q[1] is the synchronized input, sync_q[2] its previous value for edge detect.
    assign cap_evt = sync_q[1] && !sync_q[2];
    always_ff @(posedge clk_ip or posedge reset_ip) begin
        if (reset_ip) sync_q <= 3'b000;
        else          sync_q <= {sync_q[1:0], capture_ip};
    end
`else
    logic unused_capture;
    assign unused_capture = capture_ip;
    assign cap_evt = 1'b0;
`endif

    always_comb begin
        ctrl_d = wr_ctrl ? data_ip[5:0] : ctrl_q;
        cmp_d  = wr_cmp ? data_ip : cmp_q;
        cnt_d  = wr_cnt ? data_ip : (hit && ctrl_q[2]) ? 8'h00 : tick ? cnt_q + 8'd1 : cnt_q;
        psc_d  = (!en || tick || wr_cnt) ? 8'h00 : psc_q + 8'd1;
        mf_d   = hit || (mf_q && !(wr_stat && data_ip[0]));
        cf_d   = cap_evt || (cf_q && !(wr_stat && data_ip[1]));
        cap_d  = cap_evt ? cnt_q : cap_q;
    end

    always_ff @(posedge clk_ip or posedge reset_ip) begin
        if (reset_ip) begin
            ctrl_q <= 6'h00;
            cnt_q  <= 8'h00;
            cmp_q  <= 8'h00;
            psc_q  <= 8'h00;
            cap_q  <= 8'h00;
            mf_q   <= 1'b0;
            cf_q   <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            psc_q  <= psc_d;
            cap_q  <= cap_d;
            mf_q   <= mf_d;
            cf_q   <= cf_d;
        end
    end

    assign data_op = !(rd_en_ip && in_rng) ? 8'h00 :
                     off == 8'd0 ? {2'b00, ctrl_q} :
                     off == 8'd1 ? cnt_q :
                     off == 8'd2 ? cmp_q :
                     off == 8'd3 ? {6'b000000, cf_q, mf_q} : cap_q;
endmodule

// File: tb/tb_timer_peri.sv
// tb_timer_peri: table-driven and directed checks of timer_peri register, count, IRQ, reset and capture behavior
module tb_timer_peri;
    localparam logic [7:0] A_CTRL = 8'h10, A_CNT = 8'h11, A_CMP = 8'h12, A_STAT = 8'h13, A_CAP = 8'h14;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] addr = 8'h00, wdata = 8'h00, rdata;
    logic       wr = 1'b0, rd = 1'b0, cap_in = 1'b0, irq;
    int         checks = 0, errors = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_d;
        logic       exp_irq;
    } vec_t;
    vec_t tbl[33];

    timer_peri #(.BASE_ADDR(8'h10)) dut (
        .clk_ip(clk), .reset_ip(rst), .addr_ip(addr), .data_ip(wdata),
        .wr_en_ip(wr), .rd_en_ip(rd), .data_op(rdata),
        .capture_ip(cap_in), .irq_op(irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge; it is committed on the next rising edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = w; rd = r; addr = a; wdata = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr = 0; rd = 0; rst = 1;
        #3 rst = 0;
    endtask

    initial begin
        tbl = '{
            '{0,1,A_CTRL,8'h00,8'h00,0}, '{0,1,A_CNT,8'h00,8'h00,0}, '{0,1,A_STAT,8'h00,8'h00,0},
            '{1,0,A_CMP,8'h03,8'h00,0},  '{1,0,A_CTRL,8'h07,8'h00,0},
            '{0,1,A_CNT,8'h00,8'h00,0},  '{0,1,A_CNT,8'h00,8'h01,0}, '{0,1,A_CNT,8'h00,8'h02,0},
            '{0,1,A_CNT,8'h00,8'h03,0},  '{0,1,A_CNT,8'h00,8'h00,1}, '{0,1,A_STAT,8'h00,8'h01,1},
            '{1,0,A_STAT,8'h01,8'h00,1}, '{0,1,A_STAT,8'h00,8'h00,0},
            '{0,1,A_CNT,8'h00,8'h00,1},  '{0,1,A_CNT,8'h00,8'h01,1}, '{0,1,A_CNT,8'h00,8'h02,1},
            '{1,0,A_STAT,8'h01,8'h00,1}, '{0,1,A_STAT,8'h00,8'h01,1},
            '{1,0,A_CTRL,8'h06,8'h00,1}, '{0,1,A_CNT,8'h00,8'h01,1}, '{0,1,A_CNT,8'h00,8'h01,1},
            '{0,1,A_CTRL,8'h00,8'h06,1}, '{0,1,A_CMP,8'h00,8'h03,1},
            '{0,1,8'h15,8'h00,8'h00,1},  '{0,1,8'h0F,8'h00,8'h00,1},
            '{1,0,A_CAP,8'h55,8'h00,1},  '{0,1,A_CAP,8'h00,8'h00,1},
            '{1,0,A_STAT,8'h01,8'h00,1}, '{0,1,A_STAT,8'h00,8'h00,0},
            '{1,0,A_CTRL,8'hFF,8'h00,0}, '{0,1,A_CTRL,8'h00,8'h3F,0},
            '{1,0,A_CTRL,8'h00,8'h00,0}, '{0,0,A_CTRL,8'h00,8'h00,0}
        };
        #5 chk("reset_irq", {7'b0, irq}, 8'h00);
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data);
            #1;
            chk($sformatf("vec%0d_data", i), rdata, tbl[i].exp_d);
            chk($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].exp_irq});
        end

        // Prescaler 3, no auto-reload: one increment per 8 cycles, wrap at FF sets MF.
        do_reset();
        cyc(1, 0, A_CMP, 8'hFF);
        cyc(1, 0, A_CNT, 8'hFD);
        cyc(1, 0, A_CTRL, 8'h19);
        for (int k = 0; k <= 24; k++) begin
            cyc(0, 1, A_CNT, 8'h00);
            #1 chk($sformatf("psc3_cnt_k%0d", k), rdata, 8'(8'hFD + k / 8));
        end
        cyc(0, 1, A_STAT, 8'h00);
        #1 chk("psc3_wrap_mf", rdata, 8'h01);
        chk("psc3_irq_masked", {7'b0, irq}, 8'h00);

        // CNT write landing on a tick edge wins and restarts the prescaler.
        repeat (5) cyc(0, 0, A_CNT, 8'h00);
        cyc(1, 0, A_CNT, 8'h80);
        for (int j = 0; j <= 8; j++) begin
            cyc(0, 1, A_CNT, 8'h00);
            #1 chk($sformatf("cntwr_j%0d", j), rdata, j < 8 ? 8'h80 : 8'h81);
        end

        // Asynchronous reset in the middle of a count.
        do_reset();
        cyc(1, 0, A_CMP, 8'h01);
        cyc(1, 0, A_CTRL, 8'h13);
        repeat (10) cyc(0, 0, A_CNT, 8'h00);
        cyc(0, 1, A_STAT, 8'h00);
        #1 chk("pre_rst_stat", rdata, 8'h01);
        chk("pre_rst_irq", {7'b0, irq}, 8'h01);
        cyc(0, 1, A_CNT, 8'h00);
        #1 chk("pre_rst_cnt", rdata, 8'h02);
        #1 rst = 1;
        for (int a = 0; a < 5; a++) begin
            addr = 8'(A_CTRL + a);
            #1 chk($sformatf("async_rst_reg%0d", a), rdata, 8'h00);
        end
        chk("async_rst_irq", {7'b0, irq}, 8'h00);
        rd = 0;
        #1 rst = 0;
        cyc(1, 0, A_CTRL, 8'h11);
        for (int k = 0; k <= 4; k++) begin
            cyc(0, 1, A_CNT, 8'h00);
            #1 chk($sformatf("post_rst_k%0d", k), rdata, k < 4 ? 8'h00 : 8'h01);
        end

        // Capture of CNT on an external pulse; timer is stopped, capture does not depend on EN.
        do_reset();
        cyc(1, 0, A_CNT, 8'h42);
        cyc(0, 0, A_CNT, 8'h00);
        #3 cap_in = 1;
        #20 cap_in = 0;
        repeat (5) cyc(0, 0, A_CNT, 8'h00);
        cyc(0, 1, A_CAP, 8'h00);
`ifdef TIMER_PERI_CAPTURE_EN
        #1 chk("cap_value", rdata, 8'h42);
        cyc(0, 1, A_STAT, 8'h00);
        #1 chk("cap_cf", rdata, 8'h02);
        chk("cap_no_irq", {7'b0, irq}, 8'h00);
        cyc(1, 0, A_STAT, 8'h02);
        cyc(0, 1, A_STAT, 8'h00);
        #1 chk("cap_cf_clear", rdata, 8'h00);
`else
        #1 chk("nocap_value", rdata, 8'h00);
        cyc(0, 1, A_STAT, 8'h00);
        #1 chk("nocap_cf", rdata, 8'h00);
        chk("nocap_irq", {7'b0, irq}, 8'h00);
`endif
        cyc(0, 1, A_CNT, 8'h00);
        #1 chk("cap_cnt_frozen", rdata, 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
